// File: rtl/rr_arbiter7.sv
// rr_arbiter7: round-robin arbiter for seven requesters numbered 1..7.
// Issues a registered one-hot grant plus its binary index (0 = no grant).
// A grant is held until the owner asserts done, drops its request, or the
// MAX_HOLD cycle limit forces a release (flagged by a one-cycle timeout).
module rr_arbiter7 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] req,
    input  logic       done,
    output logic [6:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Last grant cycle is reached when the counter shows MAX_HOLD-1.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_e     state_q,     state_d;
    logic [2:0] last_q,      last_d;
    logic [7:0] hold_cnt_q,  hold_cnt_d;
    logic [6:0] gnt_q,       gnt_d;
    logic [2:0] gnt_idx_q,   gnt_idx_d;
    logic       busy_q,      busy_d;
    logic       timeout_q,   timeout_d;

    logic [2:0] winner_s;
    logic       owner_req_s;
    logic       limit_s;

    // Search last+1, last+2, ... wrapping 7->1 and ending with last itself;
    // returns 0 when nothing is requesting.
    function automatic logic [2:0] pick_winner(input logic [6:0] r, input logic [2:0] last);
        logic [2:0] cand;
        logic [2:0] win;
        win  = 3'd0;
        cand = last;
        for (int k = 0; k < 7; k++) begin
            cand = (cand >= 3'd7) ? 3'd1 : cand + 3'd1;
            if ((win == 3'd0) && r[cand - 3'd1]) begin
                win = cand;
            end
        end
        return win;
    endfunction

    // Binary index (1..7) to one-hot grant; 0 maps to no grant.
    function automatic logic [6:0] decode_idx(input logic [2:0] idx);
        logic [6:0] oh;
        case (idx)
            3'd1:    oh = 7'b0000001;
            3'd2:    oh = 7'b0000010;
            3'd3:    oh = 7'b0000100;
            3'd4:    oh = 7'b0001000;
            3'd5:    oh = 7'b0010000;
            3'd6:    oh = 7'b0100000;
            3'd7:    oh = 7'b1000000;
            default: oh = 7'b0000000;
        endcase
        return oh;
    endfunction

    // Request level of the requester identified by idx; 0 for idx 0.
    function automatic logic req_of(input logic [6:0] r, input logic [2:0] idx);
        logic bit_v;
        if (idx == 3'd0) begin
            bit_v = 1'b0;
        end else begin
            bit_v = r[idx - 3'd1];
        end
        return bit_v;
    endfunction

    // Next-state and next-output computation for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        winner_s    = pick_winner(req, last_q);
        owner_req_s = req_of(req, gnt_idx_q);
        limit_s     = (hold_cnt_q == HOLD_LIMIT);

        case (state_q)
            ST_IDLE: begin
                if (req != 7'd0) begin
                    state_d    = ST_GRANT;
                    gnt_d      = decode_idx(winner_s);
                    gnt_idx_d  = winner_s;
                    busy_d     = 1'b1;
                    hold_cnt_d = 8'd0;
                end else begin
                    gnt_d     = 7'd0;
                    gnt_idx_d = 3'd0;
                    busy_d    = 1'b0;
                end
            end
            ST_GRANT: begin
                if (done || !owner_req_s || limit_s) begin
                    // done and withdrawal outrank the hold limit.
                    state_d    = ST_IDLE;
                    last_d     = gnt_idx_q;
                    gnt_d      = 7'd0;
                    gnt_idx_d  = 3'd0;
                    busy_d     = 1'b0;
                    hold_cnt_d = 8'd0;
                    timeout_d  = !done && owner_req_s;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                last_d     = 3'd7;
                hold_cnt_d = 8'd0;
                gnt_d      = 7'd0;
                gnt_idx_d  = 3'd0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= 3'd7;
            hold_cnt_q <= 8'd0;
            gnt_q      <= 7'd0;
            gnt_idx_q  <= 3'd0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt     = gnt_q;
    assign gnt_idx = gnt_idx_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter7.sv
// tb_rr_arbiter7: directed scenarios plus randomized traffic for rr_arbiter7,
// checked every cycle against a behavioural owner/last/hold-count model.
module tb_rr_arbiter7;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [6:0] req;
    logic       done;
    logic [6:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int tests_run;
    int tests_failed;

    // Reference model state
    int m_owner;   // 0 = idle, else 1..7
    int m_last;    // 1..7
    int m_held;    // grant cycles elapsed for current owner
    int m_to;      // expected timeout

    int rec_idx[$];
    int rec_to[$];

    rr_arbiter7 #(.MAX_HOLD(MH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge(input logic r_rst, input logic [6:0] r_req, input logic r_done);
        int cand;
        if (r_rst) begin
            m_owner = 0; m_last = 7; m_held = 0; m_to = 0;
        end else if (m_owner == 0) begin
            m_to = 0;
            for (int k = 1; k <= 7; k++) begin
                cand = ((m_last - 1 + k) % 7) + 1;
                if (m_owner == 0 && r_req[cand-1]) m_owner = cand;
            end
            m_held = (m_owner != 0) ? 1 : 0;
        end else if (r_done || !r_req[m_owner-1]) begin
            m_last = m_owner; m_owner = 0; m_held = 0; m_to = 0;
        end else if (m_held == MH) begin
            m_last = m_owner; m_owner = 0; m_held = 0; m_to = 1;
        end else begin
            m_held++; m_to = 0;
        end
    endtask

    // Drive one cycle, update model at the edge, compare shortly after.
    task automatic step(input logic s_rst, input logic [6:0] s_req, input logic s_done);
        int exp_gnt;
        rst = s_rst; req = s_req; done = s_done;
        @(posedge clk);
        model_edge(s_rst, s_req, s_done);
        #1;
        exp_gnt = (m_owner == 0) ? 0 : (1 << (m_owner - 1));
        check_val("gnt", int'(gnt), exp_gnt);
        check_val("gnt_idx", int'(gnt_idx), m_owner);
        check_val("busy", int'(busy), (m_owner != 0) ? 1 : 0);
        check_val("timeout", int'(timeout), m_to);
        rec_idx.push_back(int'(gnt_idx));
        rec_to.push_back(int'(timeout));
    endtask

    initial begin
        int rot[$];
        int exp_hold_idx[10];
        int exp_hold_to[10];
        logic [6:0] rq;
        logic       rr;
        logic       dd;

        tests_run = 0; tests_failed = 0;
        m_owner = 0; m_last = 7; m_held = 0; m_to = 0;
        rst = 1'b1; req = 7'd0; done = 1'b0;
        @(posedge clk); #1;

        // Reset / idle
        repeat (2) step(1'b1, 7'h7F, 1'b0);
        repeat (5) step(1'b0, 7'h00, 1'b0);

        // Single requester 5, done after 3 grant cycles
        step(1'b0, 7'h10, 1'b0);
        check_val("single_idx", int'(gnt_idx), 5);
        step(1'b0, 7'h10, 1'b0);
        step(1'b0, 7'h10, 1'b0);
        step(1'b0, 7'h10, 1'b1);
        check_val("single_release", int'(gnt_idx), 0);
        step(1'b0, 7'h00, 1'b0);

        // Rotation with all requesting
        step(1'b1, 7'h00, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 7'h7F, 1'b0);
            rot.push_back(int'(gnt_idx));
            step(1'b0, 7'h7F, 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("rotation[%0d]", i), rot[i], (i % 7) + 1);
        end

        // Hold limit: requesters 2 and 6, no done (last is 1 here)
        exp_hold_idx = '{2, 2, 2, 2, 0, 6, 6, 6, 6, 0};
        exp_hold_to  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        rec_idx.delete(); rec_to.delete();
        for (int i = 0; i < 10; i++) step(1'b0, 7'b0100010, 1'b0);
        for (int i = 0; i < 10; i++) begin
            check_val($sformatf("hold_idx[%0d]", i), rec_idx[i], exp_hold_idx[i]);
            check_val($sformatf("hold_to[%0d]", i), rec_to[i], exp_hold_to[i]);
        end

        // done on the same edge as the limit
        step(1'b0, 7'h04, 1'b0);
        step(1'b0, 7'h04, 1'b0);
        step(1'b0, 7'h04, 1'b0);
        step(1'b0, 7'h04, 1'b0);
        step(1'b0, 7'h04, 1'b1);
        check_val("done_at_limit_to", int'(timeout), 0);
        check_val("done_at_limit_busy", int'(busy), 0);

        // Owner withdraws mid-grant
        step(1'b0, 7'h01, 1'b0);
        step(1'b0, 7'h01, 1'b0);
        step(1'b0, 7'h00, 1'b0);
        check_val("withdraw_busy", int'(busy), 0);
        check_val("withdraw_to", int'(timeout), 0);

        // Reset mid-grant
        step(1'b1, 7'h00, 1'b0);
        step(1'b0, 7'h08, 1'b0);
        check_val("pre_reset_idx", int'(gnt_idx), 4);
        step(1'b1, 7'h7F, 1'b0);
        check_val("mid_reset_idx", int'(gnt_idx), 0);
        step(1'b0, 7'h7F, 1'b0);
        check_val("post_reset_first", int'(gnt_idx), 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rq = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) rq = 7'd0;
            dd = ($urandom_range(0, 4) == 0);
            rr = ($urandom_range(0, 49) == 0);
            step(rr, rq, dd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rr_arbiter7.md
# rr_arbiter7

Round-robin arbiter sharing one resource among seven requesters numbered 1..7, matching the d1..d7 one-hot lines of the 3-to-7 decoder and 7-to-3 encoder pair. It issues a registered one-hot grant and its 3-bit binary index, with 0 meaning no grant. The grant is held until the owner releases it or a hold-time limit expires. The arbiter sits in front of the encoder/decoder datapath and decides which source drives it each transaction.

## Interface
- MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 1..255.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req  in  7  request vector, bit i-1 = requester i (d1..d7 ordering); level-sensitive.
- done  in  1  owner release strobe; only meaningful while busy=1.
- gnt  out  7  one-hot grant, same bit ordering as req; all-zero when idle.
- gnt_idx  out  3  binary index of current owner (1..7), 0 when idle; always equals encoder(gnt).
- busy  out  1  high while a grant is held.
- timeout  out  1  one-cycle pulse, high in the cycle after a forced (MAX_HOLD) release.

## Operation
- Internal state:
  - FSM {IDLE, GRANT}.
  - last[2:0]: most recent owner, 1..7.
  - hold_cnt[7:0].
- Reset (rst=1 at a clock edge, dominant over all other inputs, including mid-grant):
  - FSM=IDLE, last=7, hold_cnt=0.
  - gnt=0, gnt_idx=0, busy=0, timeout=0.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first set requester searching last+1, last+2, …, wrapping 7→1, ending with last itself. last is eligible only if no other requester is set.
  - At the edge: FSM→GRANT, gnt/gnt_idx←winner, busy←1, hold_cnt←0.
- GRANT: the release condition is evaluated at each edge, in priority order:
  1. done=1: normal release, timeout←0.
  2. req[owner]=0: owner withdrew, normal release, timeout←0.
  3. hold_cnt==MAX_HOLD-1: forced release, timeout←1.
  4. Otherwise: hold_cnt←hold_cnt+1, outputs unchanged.
- On any release: FSM→IDLE, last←owner, gnt=0, gnt_idx=0, busy=0.
- timeout clears after one cycle; it is also 0 in every other cycle.
- Changes to non-owner req bits during GRANT are ignored; no preemption.
- done while IDLE is ignored.
- Fairness: with all seven requesting continuously, grants rotate 1,2,3,4,5,6,7,1,…

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Grant latency is one cycle. Request seen in IDLE at edge N → gnt valid from edge N (visible in cycle N+1).
- Release latency is one cycle. Release condition at edge M → gnt=0 in cycle M+1.
- Minimum one IDLE cycle between consecutive grants. Back-to-back throughput is MAX_HOLD grant cycles + 1 idle cycle per owner.
- MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses unless done or req-drop is also present.
- done and the hold limit at the same edge: done wins, timeout=0.
- Every cycle: gnt is zero or one-hot, and gnt_idx matches it.

## Test plan
- Reset/idle:
  - Stimulus: rst=1 for 2 cycles with req=7'h7F, then req=0 for 5 cycles.
  - Response: gnt=0, gnt_idx=0, busy=0, timeout=0 throughout.
- Single requester:
  - Stimulus: req=bit for requester 5 only, done pulsed 3 cycles after grant.
  - Response: gnt_idx=5 one cycle after req, held 3 cycles, 0 the cycle after done; last=5.
- Rotation:
  - Stimulus: req=7'h7F constant, done pulsed the cycle after each grant.
  - Response: gnt_idx sequence 1,2,3,4,5,6,7,1 separated by idle cycles.
- Hold limit:
  - Stimulus: MAX_HOLD=4, req requesters 2 and 6, no done.
  - Response: gnt_idx=2 for exactly 4 cycles, timeout=1 for one cycle, then gnt_idx=6 for 4 cycles.
- Simultaneous/withdraw:
  - Stimulus 1: done asserted on the same edge as the limit. Response: release, timeout stays 0.
  - Stimulus 2: owner drops req mid-grant. Response: release next cycle, no timeout.
- Reset mid-grant:
  - Stimulus: rst=1 while gnt_idx=4, then req=7'h7F.
  - Response: outputs 0 next cycle; first post-reset grant is gnt_idx=1 (last restored to 7).
